// File: rtl/fpu_sp_pkg.sv
// Shared constants, request layout and FSM state type for the single-precision FPU issuer.
// The optional WAIT watchdog is enabled with FPU_SP_ISSUE_TIMEOUT_EN.
package fpu_sp_pkg;

   localparam logic [3:0]  CMD_FPU_SP_ADD = 4'd1;
   localparam logic [3:0]  CMD_FPU_SP_SUB = 4'd2;
   localparam logic [3:0]  CMD_FPU_SP_MUL = 4'd3;
   localparam logic [3:0]  CMD_FPU_SP_DIV = 4'd4;

   localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

   // Request word is {cmd, a, b}
   localparam int REQ_W = 4 + 32 + 32;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      HOLD
   } issuer_state_t;

   function automatic logic cmd_is_legal(input logic [3:0] cmd);
      return (cmd >= CMD_FPU_SP_ADD) && (cmd <= CMD_FPU_SP_DIV);
   endfunction

endpackage

// File: rtl/fpu_sp_req_fifo.sv
// Synchronous request FIFO with a fall-through head; a count register separates full from empty.
module fpu_sp_req_fifo
   import fpu_sp_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [REQ_W-1:0] push_data,
   input  logic             pop,
   output logic [REQ_W-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [REQ_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == (PTR_W+1)'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: the head is only consumed when count says it is valid
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fpu_sp_issuer.sv
// Queues host FPU requests and issues them one at a time to the FPU, returning each result in order.
// Define FPU_SP_ISSUE_TIMEOUT_EN to abort a WAIT that exceeds TIMEOUT_CYCLES.
//
// state | meaning
// IDLE  | pop the FIFO head when present; legal -> ISSUE, illegal -> HOLD
// ISSUE | single-cycle fpu_dval pulse with operands on fpu_*
// WAIT  | operands held; first fpu_rdy (or watchdog expiry) captures the result
// HOLD  | out_valid high until out_ready
module fpu_sp_issuer
   import fpu_sp_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_cmd,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic [3:0]  fpu_cmd,
   output logic [31:0] fpu_din1,
   output logic [31:0] fpu_din2,
   output logic        fpu_dval,
   input  logic [31:0] fpu_result,
   input  logic        fpu_rdy,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic [3:0]  out_cmd,
   output logic        out_illegal,
   output logic        out_timeout,
   output logic        busy
);

   issuer_state_t    state_q;
   issuer_state_t    state_d;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_pop;
   logic [REQ_W-1:0] head;
   logic [3:0]       head_cmd;
   logic [31:0]      head_a;
   logic [31:0]      head_b;
   logic             load_issue;
   logic             load_illegal;
   logic             capture_result;
   logic             capture_timeout;
   logic             wait_expired;

   assign in_ready = rst_n && !fifo_full;

   fpu_sp_req_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_req_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (in_valid && in_ready),
      .push_data ({in_cmd, in_a, in_b}),
      .pop       (fifo_pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign {head_cmd, head_a, head_b} = head;

`ifdef FPU_SP_ISSUE_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMR_W-1:0] tmr_q;

   // Down-counter reloads on the way into ISSUE and only runs while in WAIT
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tmr_q <= '0;
      end else if (load_issue) begin
         tmr_q <= TMR_W'(TIMEOUT_CYCLES - 1);
      end else if ((state_q == WAIT) && (tmr_q != '0)) begin
         tmr_q <= tmr_q - TMR_W'(1);
      end
   end

   assign wait_expired = (state_q == WAIT) && (tmr_q == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_timeout <= 1'b0;
      end else if (load_issue || load_illegal) begin
         out_timeout <= 1'b0;
      end else if (capture_timeout) begin
         out_timeout <= 1'b1;
      end
   end
`else
   // No watchdog in this build: WAIT lasts until fpu_rdy, so expiry can never fire
   assign wait_expired = (TIMEOUT_CYCLES < 0);
   assign out_timeout  = 1'b0;
`endif

   always_comb begin
      state_d         = state_q;
      fifo_pop        = 1'b0;
      load_issue      = 1'b0;
      load_illegal    = 1'b0;
      capture_result  = 1'b0;
      capture_timeout = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               if (cmd_is_legal(head_cmd)) begin
                  load_issue = 1'b1;
                  state_d    = ISSUE;
               end else begin
                  load_illegal = 1'b1;
                  state_d      = HOLD;
               end
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (fpu_rdy) begin
               capture_result = 1'b1;
               state_d        = HOLD;
            end else if (wait_expired) begin
               capture_timeout = 1'b1;
               state_d         = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         fpu_cmd     <= '0;
         fpu_din1    <= '0;
         fpu_din2    <= '0;
         out_result  <= '0;
         out_cmd     <= '0;
         out_illegal <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load_issue) begin
            fpu_cmd     <= head_cmd;
            fpu_din1    <= head_a;
            fpu_din2    <= head_b;
            out_cmd     <= head_cmd;
            out_illegal <= 1'b0;
         end
         if (load_illegal) begin
            out_result  <= FP_QNAN;
            out_cmd     <= head_cmd;
            out_illegal <= 1'b1;
         end
         if (capture_result)  out_result <= fpu_result;
         if (capture_timeout) out_result <= FP_QNAN;
      end
   end

   assign fpu_dval  = (state_q == ISSUE);
   assign out_valid = (state_q == HOLD);
   assign busy      = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_fpu_sp_issuer.sv
// Directed bench for fpu_sp_issuer with a behavioural FPU stub answering from a fixed result table.
// Covers the FPU_SP_ISSUE_TIMEOUT_EN build as well when that macro is defined.
`timescale 1ns/1ps
module tb_fpu_sp_issuer;
   import fpu_sp_pkg::*;

   localparam int DEPTH = 4;
   localparam int TMO   = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  in_cmd = '0;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic [3:0]  fpu_cmd;
   logic [31:0] fpu_din1;
   logic [31:0] fpu_din2;
   logic        fpu_dval;
   logic [31:0] fpu_result;
   logic        fpu_rdy;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_result;
   logic [3:0]  out_cmd;
   logic        out_illegal;
   logic        out_timeout;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int dval_cnt = 0;
   int rdy_cnt = 0;
   int stab_err = 0;
   bit stub_en = 1'b1;
   bit stub_chk = 1'b1;
   int stub_lat = 2;

   always #5 clk = ~clk;

   fpu_sp_issuer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_cmd(in_cmd), .in_a(in_a), .in_b(in_b),
      .fpu_cmd(fpu_cmd), .fpu_din1(fpu_din1), .fpu_din2(fpu_din2), .fpu_dval(fpu_dval),
      .fpu_result(fpu_result), .fpu_rdy(fpu_rdy),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_cmd(out_cmd), .out_illegal(out_illegal), .out_timeout(out_timeout), .busy(busy)
   );

   function automatic logic [31:0] fpu_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      case ({c, a, b})
         {4'd1, 32'h3F800000, 32'h40000000}: return 32'h40400000;
         {4'd2, 32'h40000000, 32'h3F800000}: return 32'h3F800000;
         {4'd3, 32'hC0400000, 32'h40400000}: return 32'hC1100000;
         {4'd4, 32'h40400000, 32'h40400000}: return 32'h3F800000;
         default:                            return 32'hDEADBEEF;
      endcase
   endfunction

   // FPU stub: latches operands on fpu_dval, answers stub_lat cycles later with a one-cycle rdy
   initial begin : fpu_stub
      bit pend;
      int lat;
      logic [3:0]  c;
      logic [31:0] a;
      logic [31:0] b;
      pend = 1'b0; lat = 0; c = '0; a = '0; b = '0;
      fpu_rdy = 1'b0;
      fpu_result = '0;
      forever begin
         @(negedge clk);
         fpu_rdy = 1'b0;
         if (fpu_dval === 1'b1) begin
            dval_cnt++;
            pend = 1'b1; lat = stub_lat;
            c = fpu_cmd; a = fpu_din1; b = fpu_din2;
         end else if (pend && stub_en) begin
            if (lat > 0) begin
               lat--;
            end else begin
               if (stub_chk && (fpu_cmd !== c || fpu_din1 !== a || fpu_din2 !== b)) stab_err++;
               fpu_rdy = 1'b1;
               fpu_result = fpu_model(c, a, b);
               rdy_cnt++;
               pend = 1'b0;
            end
         end
      end
   end

   task automatic push(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, output bit ok);
      int n;
      n = 0;
      in_valid = 1'b1; in_cmd = c; in_a = a; in_b = b;
      while (in_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      ok = (in_ready === 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output bit ok, output int n);
      n = 0;
      while (out_valid !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      ok = (out_valid === 1'b1);
   endtask

   task automatic take_out();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low: got %b expected 0", in_ready); end
      rst_n = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_high: got %b expected 1", in_ready); end
      checks++; if (fpu_dval !== 1'b0) begin errors++; $display("FAIL reset_fpu_dval: got %b expected 0", fpu_dval); end
      checks++; if (fpu_cmd !== 4'h0) begin errors++; $display("FAIL reset_fpu_cmd: got %h expected 0", fpu_cmd); end
      checks++; if (fpu_din1 !== 32'h0 || fpu_din2 !== 32'h0) begin errors++; $display("FAIL reset_fpu_din: got %h/%h expected 0/0", fpu_din1, fpu_din2); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL reset_out_result: got %h expected 0", out_result); end
      checks++; if (out_cmd !== 4'h0) begin errors++; $display("FAIL reset_out_cmd: got %h expected 0", out_cmd); end
      checks++; if (out_illegal !== 1'b0 || out_timeout !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b/%b expected 0/0", out_illegal, out_timeout); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      @(negedge clk);
   endtask

   task automatic test_add();
      bit ok;
      int n;
      int d0;
      d0 = dval_cnt;
      stub_lat = 2;
      in_valid = 1'b1; in_cmd = CMD_FPU_SP_ADD; in_a = 32'h3F800000; in_b = 32'h40000000;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_accept: got in_ready=%b expected 1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (fpu_dval !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL add_cycle1: got dval=%b busy=%b expected 0/1", fpu_dval, busy); end
      @(negedge clk);
      checks++; if (fpu_dval !== 1'b1) begin errors++; $display("FAIL add_dval_latency: got %b expected 1", fpu_dval); end
      checks++; if (fpu_cmd !== 4'd1 || fpu_din1 !== 32'h3F800000 || fpu_din2 !== 32'h40000000)
         begin errors++; $display("FAIL add_fpu_operands: got %h %h %h expected 1 3f800000 40000000", fpu_cmd, fpu_din1, fpu_din2); end
      wait_valid(ok, n);
      checks++; if (!ok || n != 4) begin errors++; $display("FAIL add_out_latency: got valid=%b after %0d cycles expected 1 after 4", ok, n); end
      checks++; if (out_result !== 32'h40400000) begin errors++; $display("FAIL add_result: got %h expected 40400000", out_result); end
      checks++; if (out_cmd !== 4'd1 || out_illegal !== 1'b0) begin errors++; $display("FAIL add_cmd_flags: got cmd=%h illegal=%b expected 1/0", out_cmd, out_illegal); end
      checks++; if (dval_cnt != d0 + 1) begin errors++; $display("FAIL add_dval_pulses: got %0d expected %0d", dval_cnt - d0, 1); end
      take_out();
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL add_release: got valid=%b busy=%b expected 0/0", out_valid, busy); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_res [5];
      logic [3:0]  exp_cmd [5];
      bit ok;
      bit all_ok;
      int n;
      exp_res[0] = 32'h3F800000; exp_cmd[0] = CMD_FPU_SP_SUB;
      exp_res[1] = 32'hC1100000; exp_cmd[1] = CMD_FPU_SP_MUL;
      exp_res[2] = 32'h3F800000; exp_cmd[2] = CMD_FPU_SP_DIV;
      exp_res[3] = 32'h40400000; exp_cmd[3] = CMD_FPU_SP_ADD;
      exp_res[4] = 32'h3F800000; exp_cmd[4] = CMD_FPU_SP_SUB;
      out_ready = 1'b0;
      stub_lat = 3;
      all_ok = 1'b1;
      push(CMD_FPU_SP_SUB, 32'h40000000, 32'h3F800000, ok); all_ok &= ok;
      push(CMD_FPU_SP_MUL, 32'hC0400000, 32'h40400000, ok); all_ok &= ok;
      push(CMD_FPU_SP_DIV, 32'h40400000, 32'h40400000, ok); all_ok &= ok;
      push(CMD_FPU_SP_ADD, 32'h3F800000, 32'h40000000, ok); all_ok &= ok;
      push(CMD_FPU_SP_SUB, 32'h40000000, 32'h3F800000, ok); all_ok &= ok;
      checks++; if (!all_ok) begin errors++; $display("FAIL b2b_pushes: got accepted=%b expected 1", all_ok); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: got in_ready=%b expected 0", in_ready); end
      for (int i = 0; i < 5; i++) begin
         wait_valid(ok, n);
         checks++; if (!ok) begin errors++; $display("FAIL b2b_valid_%0d: got out_valid=0 after %0d cycles expected 1", i, n); end
         checks++; if (out_result !== exp_res[i] || out_cmd !== exp_cmd[i])
            begin errors++; $display("FAIL b2b_result_%0d: got %h cmd %h expected %h cmd %h", i, out_result, out_cmd, exp_res[i], exp_cmd[i]); end
         take_out();
         if (i == 0) begin
            @(negedge clk);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_recover: got %b expected 1", in_ready); end
         end
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_drained: got busy=%b expected 0", busy); end
      checks++; if (stab_err != 0) begin errors++; $display("FAIL b2b_operand_stable: got %0d changes expected 0", stab_err); end
   endtask

   task automatic test_illegal();
      bit ok;
      int n;
      int d0;
      d0 = dval_cnt;
      push(4'hF, 32'h00000001, 32'h00000002, ok);
      wait_valid(ok, n);
      checks++; if (!ok) begin errors++; $display("FAIL illegal_valid: got 0 expected 1"); end
      checks++; if (out_result !== FP_QNAN) begin errors++; $display("FAIL illegal_result: got %h expected 7fc00000", out_result); end
      checks++; if (out_illegal !== 1'b1 || out_cmd !== 4'hF) begin errors++; $display("FAIL illegal_flags: got illegal=%b cmd=%h expected 1/f", out_illegal, out_cmd); end
      checks++; if (dval_cnt != d0) begin errors++; $display("FAIL illegal_no_dval: got %0d pulses expected 0", dval_cnt - d0); end
      take_out();
   endtask

   task automatic test_hold();
      bit ok;
      int n;
      int d0;
      int bad;
      d0 = dval_cnt;
      bad = 0;
      stub_lat = 1;
      push(CMD_FPU_SP_ADD, 32'h3F800000, 32'h40000000, ok);
      push(CMD_FPU_SP_MUL, 32'hC0400000, 32'h40400000, ok);
      wait_valid(ok, n);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || out_result !== 32'h40400000 || out_cmd !== 4'd1 || fpu_dval !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL hold_stable: got %0d unstable cycles expected 0", bad); end
      checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL hold_illegal_clear: got %b expected 0", out_illegal); end
      checks++; if (dval_cnt != d0 + 1) begin errors++; $display("FAIL hold_no_issue: got %0d pulses expected 1", dval_cnt - d0); end
      take_out();
      wait_valid(ok, n);
      checks++; if (!ok || out_result !== 32'hC1100000) begin errors++; $display("FAIL hold_next_result: got %h expected c1100000", out_result); end
      take_out();
   endtask

   task automatic test_reset_mid();
      bit ok;
      int n;
      int r0;
      int bad;
      bad = 0;
      stub_en = 1'b0;
      stub_chk = 1'b0;
      stub_lat = 0;
      r0 = rdy_cnt;
      push(CMD_FPU_SP_ADD, 32'h3F800000, 32'h40000000, ok);
      n = 0;
      while (fpu_dval !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      checks++; if (fpu_dval !== 1'b1) begin errors++; $display("FAIL rstmid_issue: got dval=0 expected 1"); end
      push(CMD_FPU_SP_MUL, 32'hC0400000, 32'h40400000, ok);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      stub_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0 || busy !== 1'b0 || fpu_dval !== 1'b0) bad++;
      end
      checks++; if (rdy_cnt != r0 + 1) begin errors++; $display("FAIL rstmid_late_rdy: got %0d rdy pulses expected 1", rdy_cnt - r0); end
      checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_quiet: got %0d active cycles expected 0", bad); end
      checks++; if (out_result !== 32'h0 || out_cmd !== 4'h0) begin errors++; $display("FAIL rstmid_out: got %h cmd %h expected 0/0", out_result, out_cmd); end
      checks++; if (fpu_cmd !== 4'h0 || fpu_din1 !== 32'h0) begin errors++; $display("FAIL rstmid_fpu: got %h %h expected 0/0", fpu_cmd, fpu_din1); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); end
      stub_chk = 1'b1;
   endtask

   task automatic test_timeout();
      bit ok;
      int n;
      int bad;
      bad = 0;
      stub_en = 1'b0;
      push(CMD_FPU_SP_DIV, 32'h40400000, 32'h40400000, ok);
      n = 0;
      while (fpu_dval !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      checks++; if (fpu_dval !== 1'b1) begin errors++; $display("FAIL timeout_issue: got dval=0 expected 1"); end
`ifdef FPU_SP_ISSUE_TIMEOUT_EN
      wait_valid(ok, n);
      checks++; if (!ok || n != TMO + 1) begin errors++; $display("FAIL timeout_latency: got valid=%b after %0d expected 1 after %0d", ok, n, TMO + 1); end
      checks++; if (out_timeout !== 1'b1 || out_result !== FP_QNAN) begin errors++; $display("FAIL timeout_out: got to=%b %h expected 1 7fc00000", out_timeout, out_result); end
      checks++; if (out_illegal !== 1'b0 || out_cmd !== 4'd4) begin errors++; $display("FAIL timeout_cmd: got illegal=%b cmd=%h expected 0/4", out_illegal, out_cmd); end
      take_out();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_release: got busy=%b expected 0", busy); end
`else
      for (int i = 0; i < 5 * TMO; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0 || out_timeout !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL no_timeout_wait: got %0d early cycles expected 0", bad); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL no_timeout_busy: got %b expected 1", busy); end
`endif
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_add();
      test_back_to_back();
      test_illegal();
      test_hold();
      test_reset_mid();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fpu_sp_issuer.md
Name: fpu_sp_issuer

Overview:
- Hardware initiator for the single-precision FPU command interface (`cmd`/`din1`/`din2`/`dval` -> `result`/`rdy`).
- Accepts operation requests from a host over valid/ready and buffers them in a small FIFO.
- Issues one operation at a time to the FPU, waits for `rdy`, and returns the result with its command on a valid/ready output.
- Sits between a control processor/DMA and `fpu_sp_top`, replacing ad-hoc pulse sequencing.

Parameters:
- FIFO_DEPTH, 4, request FIFO entries; power of two, >=2.
- TIMEOUT_CYCLES, 64, maximum WAIT cycles before abort (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  host request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_cmd  in  4  1=ADD 2=SUB 3=MUL 4=DIV
- in_a  in  32  operand 1 (IEEE-754 SP)
- in_b  in  32  operand 2
- fpu_cmd  out  4  command to FPU
- fpu_din1  out  32  operand 1 to FPU
- fpu_din2  out  32  operand 2 to FPU
- fpu_dval  out  1  one-cycle issue pulse
- fpu_result  in  32  FPU result
- fpu_rdy  in  1  FPU result ready
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_result  out  32  result
- out_cmd  out  4  command that produced out_result
- out_illegal  out  1  command was not 1..4; result forced to 32'h7FC00000
- out_timeout  out  1  FPU did not respond (optional feature)
- busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (rst_n=0 sampled on a clk edge) forces the following; reset mid-operation abandons any in-flight op, and a late fpu_rdy after reset is ignored in IDLE:
  - FIFO empty, FSM=IDLE
  - fpu_dval=0, fpu_cmd=0, fpu_din1=0, fpu_din2=0
  - out_valid=0, out_result=0, out_cmd=0, out_illegal=0, out_timeout=0
  - busy=0, in_ready=0 during reset and 1 the first cycle after
- FIFO:
  - in_ready = !full.
  - Push on in_valid && in_ready.
  - Pop only in IDLE when non-empty.
  - Push and pop in the same cycle are both honoured.
  - Pointers wrap modulo FIFO_DEPTH; a count register distinguishes full from empty.
- IDLE:
  - FIFO empty: stay.
  - Head is legal: pop, latch the entry into the fpu_* registers, go ISSUE.
  - Head is illegal: pop, load out_result=7FC00000, out_cmd=cmd, out_illegal=1, go HOLD; the FPU is never driven.
- ISSUE: fpu_dval=1 for exactly this cycle; go WAIT.
- WAIT:
  - fpu_cmd/din held stable from ISSUE until leaving WAIT.
  - fpu_rdy is ignored in ISSUE; the first cycle in WAIT with fpu_rdy=1 captures fpu_result into out_result and goes HOLD.
- HOLD:
  - out_valid=1, with out_result/out_cmd/flags stable until out_ready.
  - On out_valid && out_ready, out_valid is cleared and the FSM goes IDLE.
  - The next pop happens no earlier than the following cycle.
- Only one op is in flight; no reordering.
- Latency: from acceptance into an empty FIFO in IDLE, fpu_dval asserts 2 cycles later. out_valid asserts the cycle after fpu_rdy is seen in WAIT.
- fpu_cmd keeps its last value when idle; fpu_dval is never asserted outside ISSUE.

Optional Feature:
- Macro FPU_SP_ISSUE_TIMEOUT_EN.
- Defined:
  - Cycle counter runs in WAIT.
  - After TIMEOUT_CYCLES cycles without fpu_rdy: out_result=7FC00000, out_timeout=1, go HOLD.
  - The counter clears on entry to ISSUE.
- Not defined: no counter, WAIT lasts indefinitely, out_timeout tied to 0.

Decomposition:
- Package fpu_sp_pkg holds:
  - command constants CMD_FPU_SP_ADD/SUB/MUL/DIV (4-bit)
  - FP_QNAN = 32'h7FC00000
  - FSM state enum IDLE/ISSUE/WAIT/HOLD
- One sub-module, fpu_sp_req_fifo: parameterised sync FIFO of {cmd[3:0], a[31:0], b[31:0]}.
- FSM and output registers live in the top module.

Test Plan:
- ADD 3F800000+40000000 via fpu_sp_top -> exactly one fpu_dval pulse; out_result=40400000, out_cmd=1, out_illegal=0.
- Back-to-back pushes while busy: SUB 40000000,3F800000; MUL C0400000,40400000; DIV 40400000,40400000 -> outputs in order 3F800000, C1100000, 3F800000; in_ready drops after FIFO_DEPTH entries queued, then recovers.
- Illegal cmd=4'hF with operands 1,2 -> no fpu_dval; out_result=7FC00000, out_illegal=1.
- Hold out_ready=0 for 10 cycles after out_valid -> out_result stable, no new fpu_dval until the handshake completes.
- Reset asserted during WAIT, then late fpu_rdy -> all outputs at reset values, no out_valid, FIFO empty.
- With FPU_SP_ISSUE_TIMEOUT_EN and a stub FPU that never raises rdy, TIMEOUT_CYCLES=8 -> out_timeout=1 and out_result=7FC00000 after 8 WAIT cycles.
